// File: rtl/parameters_pkg.sv
// Shared types and defaults for the ALU-result-to-UART control path.
package parameters_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int RES_WIDTH      = 2 * DEF_DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI} tx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; rdata always presents the head entry.
module sync_fifo
  import parameters_pkg::*;
#(
  parameter int WIDTH = RES_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
endmodule

// File: rtl/alu_result_tx.sv
// Buffers ALU results and streams each one to the UART TX as low byte then high byte.
module alu_result_tx
  import parameters_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [2*DATA_WIDTH-1:0]       ALU_OUT,
  input  logic                          ALU_OUT_Valid,
  input  logic                          TX_Busy,
  output logic [DATA_WIDTH-1:0]         TX_P_DATA,
  output logic                          TX_D_VLD,
  output logic                          OVF_ERR,
  output logic [$clog2(FIFO_DEPTH):0]   PENDING
);
  localparam int RW = 2 * DATA_WIDTH;

  tx_state_e       state, state_nxt;
  logic [RW-1:0]   hold, fifo_rdata;
  logic            fifo_full, fifo_empty;
  logic            push, pop;

  // The head is taken only when the transmitter is free, so nothing starts under Busy.
  assign pop  = (state == IDLE) && !fifo_empty && !TX_Busy;
  assign push = ALU_OUT_Valid && (!fifo_full || pop);

  sync_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .wdata (ALU_OUT),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (PENDING)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop)      state_nxt = SEND_LO;
      SEND_LO: if (TX_Busy)  state_nxt = WAIT_LO;
      WAIT_LO: if (!TX_Busy) state_nxt = SEND_HI;
      SEND_HI: if (TX_Busy)  state_nxt = WAIT_HI;
      WAIT_HI: if (!TX_Busy) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      hold      <= '0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
      OVF_ERR   <= 1'b0;
    end else begin
      state    <= state_nxt;
      OVF_ERR  <= ALU_OUT_Valid && !push;
      TX_D_VLD <= (state_nxt == SEND_LO) || (state_nxt == SEND_HI);
      if (pop) begin
        hold      <= fifo_rdata;
        TX_P_DATA <= fifo_rdata[DATA_WIDTH-1:0];
      end else if (state == WAIT_LO && state_nxt == SEND_HI) begin
        TX_P_DATA <= hold[RW-1:DATA_WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_alu_result_tx.sv
// Bench for alu_result_tx: directed scenarios plus random traffic against a queue-based reference.
module tb_alu_result_tx;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [2*DW-1:0] ALU_OUT = '0;
  logic            ALU_OUT_Valid = 1'b0;
  logic            TX_Busy = 1'b0;
  logic [DW-1:0]   TX_P_DATA;
  logic            TX_D_VLD, OVF_ERR;
  logic [PW-1:0]   PENDING;

  alu_result_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .ALU_OUT(ALU_OUT), .ALU_OUT_Valid(ALU_OUT_Valid),
    .TX_Busy(TX_Busy), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .OVF_ERR(OVF_ERR), .PENDING(PENDING)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0, n_fail = 0, cyc = 0;
  logic [15:0] q[$];
  logic [15:0] inflight = '0;
  logic [7:0]  log_b[$];
  int nbytes = 0, npop = 0, ovf_seen = 0, pend_max = 0, first_rise = -1;
  logic vld_prev = 1'b0, cur_stb = 1'b0, cur_busy = 1'b0;
  logic [15:0] cur_data = '0;
  logic force_busy = 1'b0;
  bit   rnd_uart = 1'b0;
  int   u_dly = -1, u_len = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: results wait in q; a new low byte on the wire means the head left at that edge.
  task automatic monitor();
    int  occ0;
    bit  rise, pop, accept;
    logic [7:0] expb;
    occ0 = q.size();
    rise = TX_D_VLD && !vld_prev;
    pop  = rise && (nbytes % 2 == 0);
    if (rise) begin
      if (first_rise < 0) first_rise = cyc;
      if (pop) begin
        chk("start_while_busy", {31'd0, cur_busy}, 32'd0);
        chk("pop_when_empty", {31'd0, occ0 > 0}, 32'd1);
        if (q.size() > 0) inflight = q.pop_front();
        npop++;
      end
      expb = (nbytes % 2 == 0) ? inflight[7:0] : inflight[15:8];
      chk("tx_byte", {24'd0, TX_P_DATA}, {24'd0, expb});
      log_b.push_back(TX_P_DATA);
      nbytes++;
    end
    accept = cur_stb && (occ0 < DEPTH || pop);
    if (accept) q.push_back(cur_data);
    chk("ovf_err", {31'd0, OVF_ERR}, {31'd0, cur_stb && !accept});
    if (OVF_ERR) ovf_seen++;
    chk("pending", {{(32-PW){1'b0}}, PENDING}, q.size());
    if (int'(PENDING) > pend_max) pend_max = int'(PENDING);
    vld_prev = TX_D_VLD;
  endtask

  // UART model: Busy rises a set delay after a visible byte and stays high a set number of cycles.
  task automatic uart_update();
    int d;
    if (force_busy) begin
      TX_Busy = 1'b1; u_dly = -1; u_len = 0;
    end else if (u_len > 0) begin
      u_len--;
      if (u_len == 0) TX_Busy = 1'b0;
    end else if (u_dly > 0) begin
      u_dly--;
    end else if (u_dly == 0) begin
      TX_Busy = 1'b1; u_dly = -1;
      u_len = rnd_uart ? int'($urandom_range(1, 6)) : 10;
    end else begin
      TX_Busy = 1'b0;
      if (TX_D_VLD) begin
        d = rnd_uart ? int'($urandom_range(0, 2)) : 1;
        if (d == 0) begin
          TX_Busy = 1'b1;
          u_len = rnd_uart ? int'($urandom_range(1, 6)) : 10;
        end else u_dly = d - 1;
      end
    end
  endtask

  task automatic tick(input logic stb, input logic [15:0] d);
    @(negedge CLK);
    cyc++;
    if (!RST) monitor();
    uart_update();
    cur_busy = TX_Busy;
    ALU_OUT_Valid = stb; ALU_OUT = d;
    cur_stb = stb; cur_data = d;
  endtask

  task automatic model_clear();
    q.delete(); log_b.delete();
    nbytes = 0; npop = 0; vld_prev = 1'b0;
    u_dly = -1; u_len = 0; force_busy = 1'b0; TX_Busy = 1'b0;
    ALU_OUT_Valid = 1'b0; ALU_OUT = '0;
    cur_stb = 1'b0; cur_data = '0; cur_busy = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int quiet = 0;
    for (int i = 0; i < budget && quiet < 4; i++) begin
      tick(1'b0, 16'h0);
      if (q.size() == 0 && nbytes == 2 * npop && !TX_Busy && u_dly < 0 && u_len == 0 && !TX_D_VLD)
        quiet++;
      else quiet = 0;
    end
    chk(tag, {31'd0, quiet >= 4}, 32'd1);
  endtask

  task automatic chk_log(input string tag, input logic [7:0] exp[$]);
    chk({tag, "_len"}, log_b.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_b.size(); i++)
      chk(tag, {24'd0, log_b[i]}, {24'd0, exp[i]});
  endtask

  initial begin
    int stb_cyc, rel_cyc;
    bit found;
    logic [7:0] exp[$];

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_vld", {31'd0, TX_D_VLD}, 32'd0);
    chk("rst_data", {24'd0, TX_P_DATA}, 32'd0);
    chk("rst_ovf", {31'd0, OVF_ERR}, 32'd0);
    chk("rst_pending", {{(32-PW){1'b0}}, PENDING}, 32'd0);
    model_clear();
    RST = 1'b0;
    repeat (2) tick(1'b0, 16'h0);

    // Single result and first-byte latency
    log_b.delete(); first_rise = -1;
    tick(1'b1, 16'hA55A); stb_cyc = cyc;
    drain("single_drain", 100);
    chk("single_latency", first_rise - stb_cyc, 32'd2);
    exp = '{8'h5A, 8'hA5};
    chk_log("single_bytes", exp);
    chk("single_pending", {{(32-PW){1'b0}}, PENDING}, 32'd0);

    // Back-to-back burst
    log_b.delete(); ovf_seen = 0; pend_max = 0;
    for (int i = 1; i <= 4; i++) tick(1'b1, 16'(i));
    drain("burst_drain", 300);
    exp = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
    chk_log("burst_bytes", exp);
    chk("burst_ovf", ovf_seen, 32'd0);
    chk("burst_peak", pend_max, 32'd3);

    // Overflow while transmitter is stuck busy
    log_b.delete(); ovf_seen = 0;
    force_busy = 1'b1; tick(1'b0, 16'h0);
    for (int i = 0; i < 6; i++) tick(1'b1, 16'h0010 + 16'(i));
    repeat (2) tick(1'b0, 16'h0);
    chk("ovf_pulses", ovf_seen, 32'd2);
    chk("ovf_pending", {{(32-PW){1'b0}}, PENDING}, 32'd4);
    force_busy = 1'b0;
    drain("ovf_drain", 300);
    exp = '{8'h10, 8'h00, 8'h11, 8'h00, 8'h12, 8'h00, 8'h13, 8'h00};
    chk_log("ovf_bytes", exp);

    // Push into a full FIFO in the very cycle the head is popped
    log_b.delete(); ovf_seen = 0;
    force_busy = 1'b1; tick(1'b0, 16'h0);
    for (int i = 0; i < 4; i++) tick(1'b1, 16'h0020 + 16'(i));
    tick(1'b0, 16'h0);
    chk("pp_full", {{(32-PW){1'b0}}, PENDING}, 32'd4);
    force_busy = 1'b0;
    tick(1'b1, 16'hBEEF);
    drain("pp_drain", 300);
    chk("pp_ovf", ovf_seen, 32'd0);
    exp = '{8'h20, 8'h00, 8'h21, 8'h00, 8'h22, 8'h00, 8'h23, 8'h00, 8'hEF, 8'hBE};
    chk_log("pp_bytes", exp);

    // Reset in the middle of a result
    log_b.delete();
    force_busy = 1'b1; tick(1'b0, 16'h0);
    tick(1'b1, 16'h1234); tick(1'b1, 16'h0A0B); tick(1'b1, 16'h0C0D);
    tick(1'b0, 16'h0);
    force_busy = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick(1'b0, 16'h0);
      if (nbytes % 2 == 1 && TX_Busy && !TX_D_VLD) found = 1'b1;
    end
    chk("mid_reached", {31'd0, found}, 32'd1);
    chk("mid_pending_pre", {{(32-PW){1'b0}}, PENDING}, 32'd2);
    #1 RST = 1'b1;
    #1;
    chk("mid_rst_vld", {31'd0, TX_D_VLD}, 32'd0);
    chk("mid_rst_data", {24'd0, TX_P_DATA}, 32'd0);
    chk("mid_rst_ovf", {31'd0, OVF_ERR}, 32'd0);
    chk("mid_rst_pending", {{(32-PW){1'b0}}, PENDING}, 32'd0);
    model_clear();
    repeat (2) tick(1'b0, 16'h0);
    RST = 1'b0;
    repeat (30) tick(1'b0, 16'h0);
    chk("mid_no_resume", log_b.size(), 32'd0);

    // Busy gating: nothing starts until the cycle after Busy drops
    log_b.delete(); first_rise = -1;
    force_busy = 1'b1; tick(1'b0, 16'h0);
    tick(1'b1, 16'h5678);
    repeat (4) tick(1'b0, 16'h0);
    force_busy = 1'b0;
    tick(1'b0, 16'h0); rel_cyc = cyc;
    drain("gate_drain", 100);
    chk("gate_start", first_rise, rel_cyc + 1);
    exp = '{8'h78, 8'h56};
    chk_log("gate_bytes", exp);

    // Random traffic with a randomized UART
    rnd_uart = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 50) force_busy = 1'b1;
      if (i % 100 == 70) force_busy = 1'b0;
      tick($urandom_range(0, 2) == 0, 16'($urandom));
    end
    force_busy = 1'b0;
    drain("rand_drain", 600);
    chk("rand_all_sent", nbytes, 2 * npop);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
